// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the microcoded control unit: opcodes, the control word layout
// and the fetch length.
package cpu_ctrl_pkg;

    localparam int FETCH_STEPS = 2;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    typedef struct packed {
        logic halt;
        logic mar_in;
        logic ram_in;
        logic ram_out;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic alu_out;
        logic alu_subtract;
        logic flags_in;
        logic b_in;
        logic out_in;
        logic pc_en;
        logic pc_out;
        logic jump;
    } ctrl_word_t;

endpackage

// File: rtl/control_sequencer_step_counter.sv
// Microstep counter: wraps at STEPS-1, freezes while halting, and can be sent
// back to step 0 early when the current instruction has nothing left to do.
module step_counter #(
    parameter int STEPS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    input  logic       early_zero,
    output logic [2:0] step
);

    logic [2:0] step_q;
    logic [2:0] step_d;

    always_comb begin
        step_d = step_q;
        if (!hold) begin
            if (early_zero || (step_q == 3'(STEPS - 1))) begin
                step_d = '0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_q <= '0;
        end else begin
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control unit for the 8-bit bus CPU. Optional CTRL_EARLY_STEP_RESET_EN
// restarts fetch as soon as an instruction's remaining control words are empty.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int STEPS    = 5,
    parameter int OPCODE_W = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       carry,
    input  logic       zero,
    output logic       halt,
    output logic       mar_in,
    output logic       ram_in,
    output logic       ram_out,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       alu_out,
    output logic       alu_subtract,
    output logic       flags_in,
    output logic       b_in,
    output logic       out_in,
    output logic       pc_en,
    output logic       pc_out,
    output logic       jump,
    output logic [2:0] step
);

    logic [OPCODE_W-1:0] opcode;
    logic [2:0]          step_q;
    logic                halted_q;
    logic                halted_d;
    logic                early_zero;
    ctrl_word_t          dec;
    ctrl_word_t          ctrl;
    logic                unused_operand;

    assign opcode         = instr[7 -: OPCODE_W];
    assign unused_operand = ^instr[3:0];

    always_comb begin
        dec = '0;
        if (halted_q) begin
            dec.halt = 1'b1;
        end else begin
            case (step_q)
                3'd0: begin
                    dec.pc_out = 1'b1;
                    dec.mar_in = 1'b1;
                end
                3'd1: begin
                    dec.ram_out = 1'b1;
                    dec.ir_in   = 1'b1;
                    dec.pc_en   = 1'b1;
                end
                default: begin
                    case (opcode)
                        OP_LDA: begin
                            if (step_q == 3'd2) begin
                                dec.ir_out = 1'b1;
                                dec.mar_in = 1'b1;
                            end else if (step_q == 3'd3) begin
                                dec.ram_out = 1'b1;
                                dec.a_in    = 1'b1;
                            end
                        end
                        OP_ADD, OP_SUB: begin
                            if (step_q == 3'd2) begin
                                dec.ir_out = 1'b1;
                                dec.mar_in = 1'b1;
                            end else if (step_q == 3'd3) begin
                                dec.ram_out      = 1'b1;
                                dec.b_in         = 1'b1;
                                dec.alu_subtract = (opcode == OP_SUB);
                            end else if (step_q == 3'd4) begin
                                dec.alu_out      = 1'b1;
                                dec.a_in         = 1'b1;
                                dec.flags_in     = 1'b1;
                                dec.alu_subtract = (opcode == OP_SUB);
                            end
                        end
                        OP_STA: begin
                            if (step_q == 3'd2) begin
                                dec.ir_out = 1'b1;
                                dec.mar_in = 1'b1;
                            end else if (step_q == 3'd3) begin
                                dec.a_out  = 1'b1;
                                dec.ram_in = 1'b1;
                            end
                        end
                        OP_LDI: begin
                            if (step_q == 3'd2) begin
                                dec.ir_out = 1'b1;
                                dec.a_in   = 1'b1;
                            end
                        end
                        OP_JMP, OP_JC, OP_JZ: begin
                            // Conditional jumps look at the flags as they stand during T2.
                            if ((step_q == 3'd2) &&
                                ((opcode == OP_JMP) ||
                                 ((opcode == OP_JC) && carry) ||
                                 ((opcode == OP_JZ) && zero))) begin
                                dec.ir_out = 1'b1;
                                dec.jump   = 1'b1;
                            end
                        end
                        OP_OUT: begin
                            if (step_q == 3'd2) begin
                                dec.a_out  = 1'b1;
                                dec.out_in = 1'b1;
                            end
                        end
                        OP_HLT: begin
                            if (step_q == 3'd2) begin
                                dec.halt = 1'b1;
                            end
                        end
                        default: dec = '0;
                    endcase
                end
            endcase
        end
    end

`ifdef CTRL_EARLY_STEP_RESET_EN
    assign early_zero = (step_q >= 3'(FETCH_STEPS)) && (dec == '0);
`else
    assign early_zero = 1'b0;
`endif

    assign halted_d = halted_q | dec.halt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    step_counter #(
        .STEPS(STEPS)
    ) u_step_counter (
        .clk       (clk),
        .rst       (rst),
        .hold      (halted_d),
        .early_zero(early_zero),
        .step      (step_q)
    );

    // Outputs drop the moment reset is asserted, without waiting for a clock.
    assign ctrl = rst ? dec : '0;

    assign halt         = ctrl.halt;
    assign mar_in       = ctrl.mar_in;
    assign ram_in       = ctrl.ram_in;
    assign ram_out      = ctrl.ram_out;
    assign ir_in        = ctrl.ir_in;
    assign ir_out       = ctrl.ir_out;
    assign a_in         = ctrl.a_in;
    assign a_out        = ctrl.a_out;
    assign alu_out      = ctrl.alu_out;
    assign alu_subtract = ctrl.alu_subtract;
    assign flags_in     = ctrl.flags_in;
    assign b_in         = ctrl.b_in;
    assign out_in       = ctrl.out_in;
    assign pc_en        = ctrl.pc_en;
    assign pc_out       = ctrl.pc_out;
    assign jump         = ctrl.jump;
    assign step         = rst ? step_q : 3'd0;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, each instruction class, conditional
// jumps, halt and recovery; follows CTRL_EARLY_STEP_RESET_EN when defined.
module tb_control_sequencer;

    localparam logic [15:0] M_HALT     = 16'h8000;
    localparam logic [15:0] M_MAR_IN   = 16'h4000;
    localparam logic [15:0] M_RAM_IN   = 16'h2000;
    localparam logic [15:0] M_RAM_OUT  = 16'h1000;
    localparam logic [15:0] M_IR_IN    = 16'h0800;
    localparam logic [15:0] M_IR_OUT   = 16'h0400;
    localparam logic [15:0] M_A_IN     = 16'h0200;
    localparam logic [15:0] M_A_OUT    = 16'h0100;
    localparam logic [15:0] M_ALU_OUT  = 16'h0080;
    localparam logic [15:0] M_ALU_SUB  = 16'h0040;
    localparam logic [15:0] M_FLAGS_IN = 16'h0020;
    localparam logic [15:0] M_B_IN     = 16'h0010;
    localparam logic [15:0] M_OUT_IN   = 16'h0008;
    localparam logic [15:0] M_PC_EN    = 16'h0004;
    localparam logic [15:0] M_PC_OUT   = 16'h0002;
    localparam logic [15:0] M_JUMP     = 16'h0001;

    localparam logic [15:0] W_T0 = M_PC_OUT | M_MAR_IN;
    localparam logic [15:0] W_T1 = M_RAM_OUT | M_IR_IN | M_PC_EN;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] instr;
    logic       carry, zero;
    logic       halt, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out;
    logic       alu_out, alu_subtract, flags_in, b_in, out_in, pc_en, pc_out, jump;
    logic [2:0] step;
    logic [15:0] obs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign obs = {halt, mar_in, ram_in, ram_out, ir_in, ir_out, a_in, a_out,
                  alu_out, alu_subtract, flags_in, b_in, out_in, pc_en, pc_out, jump};

    control_sequencer dut (
        .clk         (clk),
        .rst         (rst_n),
        .instr       (instr),
        .carry       (carry),
        .zero        (zero),
        .halt        (halt),
        .mar_in      (mar_in),
        .ram_in      (ram_in),
        .ram_out     (ram_out),
        .ir_in       (ir_in),
        .ir_out      (ir_out),
        .a_in        (a_in),
        .a_out       (a_out),
        .alu_out     (alu_out),
        .alu_subtract(alu_subtract),
        .flags_in    (flags_in),
        .b_in        (b_in),
        .out_in      (out_in),
        .pc_en       (pc_en),
        .pc_out      (pc_out),
        .jump        (jump),
        .step        (step)
    );

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr = 8'h00;
        carry = 1'b0;
        zero  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            checks++;
            if (obs !== 16'h0000 || step !== 3'd0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: ctrl=%h step=%0d, required ctrl=0000 step=0", i, obs, step);
            end
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== W_T0 || step !== 3'd0) begin
            errors++;
            $display("FAIL reset_release: ctrl=%h step=%0d, required ctrl=%h step=0", obs, step, W_T0);
        end
        $display("reset: released, step=%0d ctrl=%h", step, obs);
    endtask

    // Runs one instruction starting at T0; with early step reset the instruction
    // ends on the first empty execute word.
    task automatic run_instr(input string name, input logic [7:0] ins, input logic c,
                             input logic z, input logic [15:0] e2, input logic [15:0] e3,
                             input logic [15:0] e4);
        logic [15:0] exp_w [5];
        int          bus_n;
        exp_w[0] = W_T0;
        exp_w[1] = W_T1;
        exp_w[2] = e2;
        exp_w[3] = e3;
        exp_w[4] = e4;
        instr = ins;
        carry = c;
        zero  = z;
        #1;
        for (int t = 0; t < 5; t++) begin
            checks++;
            if (obs !== exp_w[t] || step !== 3'(t)) begin
                errors++;
                $display("FAIL %s T%0d: ctrl=%h step=%0d, required ctrl=%h step=%0d",
                         name, t, obs, step, exp_w[t], t);
            end
            bus_n = int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out) + int'(pc_out);
            checks++;
            if (bus_n > 1) begin
                errors++;
                $display("FAIL %s T%0d bus_drivers: got %0d, required at most 1", name, t, bus_n);
            end
            next_cycle();
`ifdef CTRL_EARLY_STEP_RESET_EN
            if (t >= 2 && exp_w[t] == 16'h0000) break;
`endif
        end
        $display("instr %s (%h c=%0b z=%0b): done, next step=%0d", name, ins, c, z, step);
    endtask

    task automatic test_alu();
        run_instr("ADD", 8'h2A, 1'b0, 1'b0, M_IR_OUT | M_MAR_IN, M_RAM_OUT | M_B_IN,
                  M_ALU_OUT | M_A_IN | M_FLAGS_IN);
        run_instr("SUB", 8'h3A, 1'b0, 1'b0, M_IR_OUT | M_MAR_IN, M_RAM_OUT | M_B_IN | M_ALU_SUB,
                  M_ALU_OUT | M_A_IN | M_FLAGS_IN | M_ALU_SUB);
    endtask

    task automatic test_jumps();
        run_instr("JC_c0", 8'h75, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000);
        run_instr("JC_c1", 8'h75, 1'b1, 1'b0, M_IR_OUT | M_JUMP, 16'h0000, 16'h0000);
        run_instr("JZ_z1", 8'h85, 1'b0, 1'b1, M_IR_OUT | M_JUMP, 16'h0000, 16'h0000);
        run_instr("JZ_z0", 8'h85, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        run_instr("JMP", 8'h63, 1'b0, 1'b0, M_IR_OUT | M_JUMP, 16'h0000, 16'h0000);
    endtask

    task automatic test_back_to_back();
        run_instr("LDA", 8'h1E, 1'b0, 1'b0, M_IR_OUT | M_MAR_IN, M_RAM_OUT | M_A_IN, 16'h0000);
        run_instr("STA", 8'h4F, 1'b0, 1'b0, M_IR_OUT | M_MAR_IN, M_A_OUT | M_RAM_IN, 16'h0000);
        run_instr("LDI", 8'h57, 1'b0, 1'b0, M_IR_OUT | M_A_IN, 16'h0000, 16'h0000);
        run_instr("OUT", 8'hE0, 1'b0, 1'b0, M_A_OUT | M_OUT_IN, 16'h0000, 16'h0000);
        run_instr("NOP", 8'h00, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000);
        run_instr("NOP_B", 8'hB3, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    endtask

    task automatic test_halt();
        instr = 8'hF0;
        carry = 1'b0;
        zero  = 1'b0;
        next_cycle();
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs !== M_HALT || step !== 3'd2) begin
                errors++;
                $display("FAIL halt_hold cyc%0d: ctrl=%h step=%0d, required ctrl=%h step=2",
                         i, obs, step, M_HALT);
            end
            next_cycle();
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 16'h0000 || step !== 3'd0) begin
            errors++;
            $display("FAIL halt_async_reset: ctrl=%h step=%0d, required ctrl=0000 step=0", obs, step);
        end
        next_cycle();
        instr = 8'h00;
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== W_T0 || step !== 3'd0) begin
            errors++;
            $display("FAIL halt_recover: ctrl=%h step=%0d, required ctrl=%h step=0", obs, step, W_T0);
        end
        $display("halt: cleared by reset, step=%0d ctrl=%h", step, obs);
        run_instr("LDI_after", 8'h52, 1'b0, 1'b0, M_IR_OUT | M_A_IN, 16'h0000, 16'h0000);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_alu();
        test_jumps();
        test_back_to_back();
        test_halt();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, required completion within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
